// File: rtl/cbus_mem_responder.sv
// -----------------------------------------------------------------------------
// cbus_mem_responder
//
// Responder end of the simplified burst cache bus. Accepts one burst at a
// time and services it from an internal array of 64-bit words, returning one
// ready beat per transfer and last on the final beat. Used as the simulation
// memory behind the caches and as on-chip scratch RAM.
//
// The bus types are declared in cbus_pkg at the top of this file so the whole
// block lives in one source file.
//
// Parameters
//   MEM_WORDS  memory depth in 64-bit words (power of two)
//   LFSR_SEED  reset value of the stall LFSR (nonzero)
//
// Ports
//   clk     in   rising-edge clock
//   resetn  in   synchronous, active-low reset
//   creq    in   cbus_req_t  {valid, is_write, size, addr, strobe, data, len, burst}
//   cresp   out  cbus_resp_t {ready, last, data}
//
// Handshake: a request is accepted in IDLE on the first edge that sees
// creq.valid = 1. Every cycle in BURST with cresp.ready = 1 completes one
// beat at the following edge; cresp.last marks the final beat. The master
// keeps valid and the header fields stable until the last beat and drops
// valid by the DONE turnaround cycle. cresp depends only on registered state
// and the memory array, never combinationally on creq.valid.
//
// Optional feature (macro CBUS_RESP_RANDOM_STALL_EN): a 16-bit Fibonacci
// LFSR inserts pseudo-random stall cycles (ready = 0) into bursts. Without
// the macro every BURST cycle carries a beat. Functional results are the same
// in both builds.
//
// Memory contents are not reset.
// -----------------------------------------------------------------------------

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [1:0] BURST_FIXED    = 2'd0;
    localparam logic [1:0] BURST_INCR     = 2'd1;
    localparam logic [1:0] BURST_WRAP     = 2'd2;
    localparam logic [1:0] BURST_RESERVED = 2'd3;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int AW = $clog2(MEM_WORDS);

    // Elaboration-time parameter sanity checks.
    if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("cbus_mem_responder: MEM_WORDS must be a power of two");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("cbus_mem_responder: LFSR_SEED must be nonzero");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Latched transaction header and progress.
    logic [1:0]  r_state;
    logic        r_is_write;
    logic [2:0]  r_size;
    logic [63:0] r_addr;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;
    logic [7:0]  r_cnt;

    logic [63:0] r_mem [MEM_WORDS];

    logic          w_stall;
    logic          w_beat;
    logic          w_wr_beat;
    logic [AW-1:0] w_idx;
    logic [63:0]   w_step;
    logic [63:0]   w_bound;
    logic [63:0]   w_mask;
    logic [63:0]   w_next_addr;

`ifdef CBUS_RESP_RANDOM_STALL_EN
    // Fibonacci LFSR, taps 16/14/13/11, free-running while out of reset.
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Roughly one cycle in four is a stall.
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign w_beat    = (r_state == S_BURST) && !w_stall;
    // An aborting reset must not commit the beat shown in that cycle.
    assign w_wr_beat = w_beat && r_is_write && resetn;

    // Address bits above the array size are ignored, so addresses alias.
    assign w_idx = r_addr[3 +: AW];

    // Next-beat address. The wrap boundary is the total burst size in bytes;
    // the low bits step within it while the high bits stay fixed.
    always_comb begin
        w_step      = 64'd1 << r_size;
        w_bound     = ({56'd0, r_len} + 64'd1) << r_size;
        w_mask      = w_bound - 64'd1;
        w_next_addr = r_addr + w_step;
        case (r_burst)
            BURST_FIXED: w_next_addr = r_addr;
            BURST_WRAP:  w_next_addr = (r_addr & ~w_mask) | ((r_addr + w_step) & w_mask);
            default:     w_next_addr = r_addr + w_step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_is_write <= 1'b0;
            r_size     <= 3'd0;
            r_addr     <= 64'd0;
            r_len      <= 8'd0;
            r_burst    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (creq.valid) begin
                        r_is_write <= creq.is_write;
                        r_size     <= creq.size;
                        r_addr     <= creq.addr;
                        r_len      <= creq.len;
                        r_burst    <= creq.burst;
                        r_cnt      <= 8'd0;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat) begin
                        r_addr <= w_next_addr;
                        // Counter stops at len, so len = 8'hff never wraps.
                        if (r_cnt == r_len) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write merge; bytes with a clear strobe keep their contents.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            for (int b = 0; b < 8; b++) begin
                if (creq.strobe[b]) begin
                    r_mem[w_idx][8*b +: 8] <= creq.data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        cresp       = '0;
        cresp.ready = w_beat;
        cresp.last  = w_beat && (r_cnt == r_len);
        if (w_beat && !r_is_write) begin
            cresp.data = r_mem[w_idx];
        end
    end

endmodule

// File: tb/tb_cbus_mem_responder.sv
module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int MEM_WORDS = 4096;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  always #5 clk = ~clk;

  cbus_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .creq  (creq),
    .cresp (cresp)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [63:0] model_mem [int];
  int          exp_idx_q[$];
  logic [63:0] exp_q[$];       // write data per beat (0 for reads)
  bit          m_wr   = 1'b0;
  logic [7:0]  m_strb = 8'h00;
  bit          m_busy = 1'b0;
  bit          mon_en = 1'b0;
  logic [63:0] rd_log[$];
  int          beat_seen = 0;
  int          last_cnt  = 0;
  int          last_pos  = -1;

  // Single compare process: every cycle while enabled.
  always @(negedge clk) begin : mon
    int          idx;
    logic [63:0] wd;
    logic [63:0] old;
    logic [63:0] expd;
    if (mon_en) begin
      if (!m_busy) begin
        check("idle_ready", {63'd0, cresp.ready}, 64'd0);
        check("idle_last",  {63'd0, cresp.last},  64'd0);
      end else begin
`ifndef CBUS_RESP_RANDOM_STALL_EN
        check("burst_ready", {63'd0, cresp.ready}, 64'd1);
`endif
        if (cresp.ready) begin
          if (exp_idx_q.size() == 0) begin
            check("extra_beat", 64'd1, 64'd0);
          end else begin
            idx = exp_idx_q.pop_front();
            wd  = exp_q.pop_front();
            old = model_mem.exists(idx) ? model_mem[idx] : 64'hx;
            expd = m_wr ? 64'd0 : old;
            check("beat_data", cresp.data, expd);
            check("beat_last", {63'd0, cresp.last}, {63'd0, exp_idx_q.size() == 0});
            if (cresp.last) begin
              last_cnt++;
              last_pos = beat_seen;
            end
            beat_seen++;
            if (m_wr) begin
              for (int b = 0; b < 8; b++)
                if (m_strb[b]) old[8*b +: 8] = wd[8*b +: 8];
              model_mem[idx] = old;
            end else begin
              rd_log.push_back(cresp.data);
            end
            if (exp_idx_q.size() == 0) m_busy = 1'b0;
          end
        end else begin
          check("stall_last", {63'd0, cresp.last}, 64'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic [63:0] wdata_arr [256];
  int          span;
  int          lat;

  // Called at #1 after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_burst(input bit wr, input logic [2:0] size, input logic [63:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0] strb, output int o_span, output int o_lat);
    int              n;
    int              k;
    int              cyc;
    longint unsigned step;
    longint unsigned bnd;
    longint unsigned base;
    longint unsigned a;
    n    = int'(len) + 1;
    step = 64'd1 << size;
    bnd  = longint'(n) * step;
    base = addr - (addr % bnd);
    for (int i = 0; i < n; i++) begin
      if (burst == BURST_FIXED)     a = addr;
      else if (burst == BURST_WRAP) a = base + ((addr - base + longint'(i) * step) % bnd);
      else                          a = addr + longint'(i) * step;
      exp_idx_q.push_back(int'((a >> 3) % MEM_WORDS));
      exp_q.push_back(wr ? wdata_arr[i] : 64'd0);
    end
    m_wr      = wr;
    m_strb    = strb;
    beat_seen = 0;
    last_cnt  = 0;
    last_pos  = -1;
    if (!wr) rd_log.delete();

    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = size;
    creq.addr     = addr;
    creq.strobe   = strb;
    creq.data     = wr ? wdata_arr[0] : 64'd0;
    creq.len      = len;
    creq.burst    = burst;
    @(posedge clk); #1;
    m_busy = 1'b1;
    k = 0; cyc = 0; o_lat = -1;
    while (k < n && cyc < 2000) begin
      cyc++;
      if (cresp.ready) begin
        if (o_lat < 0) o_lat = cyc;
        k++;
        @(posedge clk); #1;
        if (k < n && wr) creq.data = wdata_arr[k];
      end else begin
        @(posedge clk); #1;
      end
    end
    o_span = cyc;
    if (k < n) begin
      check("burst_timeout", 64'(k), 64'(n));
      exp_idx_q.delete();
      exp_q.delete();
      m_busy = 1'b0;
    end
    creq = '0;
    @(posedge clk); #1;
  endtask

  task automatic check_timing(input string name, input int n);
`ifndef CBUS_RESP_RANDOM_STALL_EN
    check({name, "_span"}, 64'(span), 64'(n));
    check({name, "_lat"},  64'(lat),  64'd1);
`else
    check({name, "_beats"}, 64'(beat_seen), 64'(n));
`endif
    check({name, "_last_cnt"}, 64'(last_cnt), 64'd1);
    check({name, "_last_pos"}, 64'(last_pos), 64'(n - 1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int beats;
    int cyc;
    resetn = 1'b0;
    creq   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, cresp.ready}, 64'd0);
    check("reset_last",  {63'd0, cresp.last},  64'd0);
    check("reset_data",  cresp.data, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // INCR write then read
    for (int i = 0; i < 4; i++) wdata_arr[i] = 64'(i + 1);
    run_burst(1'b1, MSIZE8, 64'h8000_0000, 8'd3, BURST_INCR, 8'hff, span, lat);
    check_timing("incr_wr", 4);
    run_burst(1'b0, MSIZE8, 64'h8000_0000, 8'd3, BURST_INCR, 8'hff, span, lat);
    check_timing("incr_rd", 4);
    check("incr_rd_n", 64'(rd_log.size()), 64'd4);
    check("incr_rd0", rd_log[0], 64'd1);
    check("incr_rd1", rd_log[1], 64'd2);
    check("incr_rd2", rd_log[2], 64'd3);
    check("incr_rd3", rd_log[3], 64'd4);

    // Strobe merge
    wdata_arr[0] = 64'h1111_1111_1111_1111;
    run_burst(1'b1, MSIZE8, 64'h8000_0020, 8'd0, BURST_INCR, 8'hff, span, lat);
    wdata_arr[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    run_burst(1'b1, MSIZE8, 64'h8000_0020, 8'd0, BURST_INCR, 8'h0f, span, lat);
    run_burst(1'b0, MSIZE8, 64'h8000_0020, 8'd0, BURST_INCR, 8'hff, span, lat);
    check_timing("merge_rd", 1);
    check("merge_val", rd_log[0], 64'h1111_1111_CCCC_DDDD);

    // WRAP order: words 2,3,0,1 of the 32-byte block
    run_burst(1'b0, MSIZE8, 64'h8000_0010, 8'd3, BURST_WRAP, 8'hff, span, lat);
    check_timing("wrap_rd", 4);
    check("wrap_rd0", rd_log[0], 64'd3);
    check("wrap_rd1", rd_log[1], 64'd4);
    check("wrap_rd2", rd_log[2], 64'd1);
    check("wrap_rd3", rd_log[3], 64'd2);

    // FIXED: same word four times
    run_burst(1'b0, MSIZE8, 64'h8000_0008, 8'd3, BURST_FIXED, 8'hff, span, lat);
    check_timing("fixed_rd", 4);
    for (int i = 0; i < 4; i++) check("fixed_rd_val", rd_log[i], 64'd2);

    // Aliasing: bit 15 is above the 4096-word index
    run_burst(1'b0, MSIZE8, 64'h8000_8000, 8'd0, BURST_INCR, 8'hff, span, lat);
    check("alias_val", rd_log[0], 64'd1);

    // Reset during beat 3 of an 8-beat read
    mon_en        = 1'b0;
    creq          = '0;
    creq.valid    = 1'b1;
    creq.size     = MSIZE8;
    creq.addr     = 64'h8000_0000;
    creq.len      = 8'd7;
    creq.burst    = BURST_INCR;
    @(posedge clk); #1;
    beats = 0; cyc = 0;
    while (cyc < 200) begin
      cyc++;
      if (cresp.ready) begin
        beats++;
        if (beats == 3) break;
      end
      @(posedge clk); #1;
    end
    check("rst_mid_reached_beat3", 64'(beats), 64'd3);
    resetn = 1'b0;
    creq   = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("rst_mid_ready", {63'd0, cresp.ready}, 64'd0);
    check("rst_mid_last",  {63'd0, cresp.last},  64'd0);
    check("rst_mid_data",  cresp.data, 64'd0);
    mon_en = 1'b1;
    run_burst(1'b0, MSIZE8, 64'h8000_0010, 8'd0, BURST_INCR, 8'hff, span, lat);
    check_timing("after_rst_rd", 1);
    check("after_rst_val", rd_log[0], 64'd3);

    // 16-beat read (stall behaviour differs by build)
    for (int i = 0; i < 16; i++) wdata_arr[i] = 64'h100 + 64'(i);
    run_burst(1'b1, MSIZE8, 64'h9000_0000, 8'd15, BURST_INCR, 8'hff, span, lat);
    run_burst(1'b0, MSIZE8, 64'h9000_0000, 8'd15, BURST_INCR, 8'hff, span, lat);
    check_timing("len16_rd", 16);
    check("len16_first", rd_log[0],  64'h100);
    check("len16_tail",  rd_log[15], 64'h10F);
`ifdef CBUS_RESP_RANDOM_STALL_EN
    n_checks++;
    if (span <= 16) begin
      n_fail++;
      $display("FAIL len16_gaps: span %0d cycles, required more than 16", span);
    end
`endif

    // Maximum length: 256 beats
    for (int i = 0; i < 256; i++) wdata_arr[i] = {32'hC0DE_0000, 32'(i)};
    run_burst(1'b1, MSIZE8, 64'hA000_0000, 8'hff, BURST_INCR, 8'hff, span, lat);
    check_timing("len256_wr", 256);
    run_burst(1'b0, MSIZE8, 64'hA000_0000, 8'hff, BURST_INCR, 8'hff, span, lat);
    check_timing("len256_rd", 256);
    check("len256_n",    64'(rd_log.size()), 64'd256);
    check("len256_tail", rd_log[255], 64'hC0DE_0000_0000_00FF);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_mem_responder.md
# cbus_mem_responder

Responder (slave) end of the simplified burst cache bus (`cbus_req_t` / `cbus_resp_t`). It accepts one burst transaction at a time from a cache or arbiter master and services it from an internal 8-byte-wide memory array, returning one `cresp.ready` beat per transfer and `cresp.last` on the final beat. It serves as the simulation memory backend behind the caches and as an on-chip scratch RAM.

## Interface
- `MEM_WORDS`, default 4096: memory depth in 64-bit words; must be a power of two.
- `LFSR_SEED`, default 16'hACE1: reset value of the stall LFSR; must be nonzero. Used only when the stall feature is compiled in.

- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset; synchronous and active-low.
- `creq`  in  151 (`cbus_req_t`)  request from the master, with fields valid, is_write, size, addr, strobe, data, len and burst.
- `cresp`  out  66 (`cbus_resp_t`)  response to the master, with fields ready, last and data.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - When `creq.valid` = 1, latch is_write, size, addr, len and burst, clear the beat counter, and go to BURST.
  - No beat is produced in the acceptance cycle.
- BURST:
  - The master holds valid and the header fields stable for the whole transaction.
  - A beat completes in each cycle with `cresp.ready` = 1.
  - Read beat: `cresp.data` = mem[idx], where idx = cur_addr[3 +: log2(MEM_WORDS)]. Higher address bits are ignored, so the address aliases modulo the array size.
  - Write beat: for each byte b with `creq.strobe[b]` = 1, mem[idx] byte b ← `creq.data` byte b. Bytes whose strobe bit is 0 are unchanged. `cresp.data` = 0.
  - `cresp.last` = 1 exactly when beat counter == len, and only on a ready beat. After the last beat, go to DONE.
  - After each beat, advance cur_addr by step = 1 << size bytes:
    - FIXED: cur_addr is unchanged.
    - INCR: cur_addr += step.
    - WRAP: with boundary B = (len+1) << size, cur_addr = (cur_addr & ~(B−1)) | ((cur_addr+step) & (B−1)).
    - RESERVED: treated as INCR.
- DONE:
  - Lasts one turnaround cycle with ready = 0 and `creq` ignored, then go to IDLE.
  - The master must have dropped valid by this cycle. A valid seen in the following IDLE cycle is a new request.
- Data placement follows the 8-byte lane convention: sub-word data sits in its lane, and the strobe selects the bytes.
- The memory contents are not reset.

## Timing
- Reset (`resetn` = 0 at a clock edge):
  - state = IDLE, beat counter = 0, LFSR = `LFSR_SEED`.
  - `cresp` = {ready 0, last 0, data 0} in the following cycle.
- `cresp` is combinational from the state registers and the memory array. There is no path from `creq.valid` to `cresp`.
- Latency: request sampled in IDLE at cycle t → first beat in cycle t+1. A burst of N beats without stalls occupies cycles t+1 … t+N.
- Back-to-back requests: minimum spacing is N+2 cycles (accept, N beats, DONE).
- Reset mid-burst: the burst is aborted and the FSM returns to IDLE. Beats already written stay committed. `cresp.ready` = 0 from the next cycle.
- `cresp.ready` = 0 in IDLE and DONE; `cresp.last` never asserts without `cresp.ready`.
- Counter width is 8 bits, matching `mlen_t`; len = 8'hff gives 256 beats with no overflow before last.
- If `creq.valid` drops during BURST (protocol violation), the FSM still completes the latched burst. Write beats in that case use the current `creq.data`.

## Configuration
- Macro `CBUS_RESP_RANDOM_STALL_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) steps every cycle while out of reset.
  - In BURST, a cycle with lfsr[1:0] == 2'b00 is a stall: ready = 0 and last = 0, no beat completes, and the address and counter hold.
  - Stall cycles are about 25%.
- Undefined: the LFSR is absent and ready = 1 in every BURST cycle.
- Functional results (data, ordering, last placement) are identical in both builds.

## Test plan
- INCR write, then read:
  - Stimulus: write MLEN4, MSIZE8, addr 64'h8000_0000, strobe 8'hff, data 1, 2, 3, 4; then read the same range.
  - Required: 4 ready beats each time, last on beat 4 only, read data 1, 2, 3, 4.
- Strobe merge:
  - Stimulus: preload word 0x8000_0020 with 64'h1111_1111_1111_1111; write 64'hAAAA_BBBB_CCCC_DDDD with strobe 8'h0F.
  - Required: a read returns 64'h1111_1111_CCCC_DDDD.
- WRAP order:
  - Stimulus: read MLEN4, MSIZE8, WRAP at addr 0x…10.
  - Required: data from words 2, 3, 0, 1 of the 32-byte block.
- FIXED burst:
  - Stimulus: read MLEN4 at 0x…08.
  - Required: the same word returned 4 times.
- Reset mid-burst:
  - Stimulus: drive `resetn` = 0 during beat 3 of a MLEN8 read.
  - Required: ready = 0 in the next cycle. A new MLEN1 read is then served normally, with its beat 1 cycle after acceptance.
- Stall feature:
  - Stimulus: MLEN16 read in both builds.
  - Required with the macro: exactly 16 ready beats with gaps, last only on the 16th, data in order. Required without the macro: 16 consecutive ready cycles.
